// File: rtl/batch_normalization_stream.sv
// batch_normalization_stream: time-multiplexed per-channel batch normalization on a
// valid/ready stream, y = sat(((x - mean) * gamma) * inv_den + beta), optional ReLU.
module batch_normalization_stream #(
    parameter int unsigned  DATA_WIDTH = 16,
    parameter int unsigned  FRAC_BITS  = 8,
    parameter int unsigned  FILTERS    = 64,
    parameter int unsigned  DEPTH      = 1,
    parameter int unsigned  INPUT      = 30,
    parameter bit           RELU_EN    = 1'b0,
    localparam int unsigned CH_W       = (FILTERS > 1) ? $clog2(FILTERS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  relu_i,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CH_W-1:0]       out_ch,
    output logic                  out_last,
    input  logic                  prm_we,
    input  logic [1:0]            prm_sel,
    input  logic [CH_W-1:0]       prm_addr,
    input  logic [DATA_WIDTH-1:0] prm_data
);

    localparam int unsigned SPATIAL = DEPTH * INPUT * INPUT;
    localparam int unsigned POS_W   = (SPATIAL > 1) ? $clog2(SPATIAL) : 1;
    localparam int unsigned D_W     = DATA_WIDTH + 1;   // x - mean, exact
    localparam int unsigned T_W     = D_W + DATA_WIDTH; // full d * gamma product
    localparam int unsigned U_W     = T_W + DATA_WIDTH; // full t * inv_den product
    localparam int unsigned S_W     = U_W + 1;          // room for the beta add
    localparam int unsigned HI_W    = S_W - DATA_WIDTH + 1;
    localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1) << FRAC_BITS;
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Per-channel parameter file
    logic [DATA_WIDTH-1:0] beta_q  [FILTERS];
    logic [DATA_WIDTH-1:0] gamma_q [FILTERS];
    logic [DATA_WIDTH-1:0] mean_q  [FILTERS];
    logic [DATA_WIDTH-1:0] inv_q   [FILTERS];
    logic                  prm_hit;

    // Frame position counters
    logic [POS_W-1:0] pos_q, pos_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic             accept;
    logic             last_c;

    // Stage 1: centred input plus latched channel parameters
    logic                  s1_vld_q;
    logic [D_W-1:0]        s1_d_q, s1_d_d;
    logic [DATA_WIDTH-1:0] s1_gamma_q, s1_inv_q, s1_beta_q;
    logic                  s1_relu_q, s1_last_q;
    logic [CH_W-1:0]       s1_ch_q;

    // Stage 2: gamma-scaled value
    logic                  s2_vld_q;
    logic signed [T_W-1:0] s2_prod;
    logic [T_W-1:0]        s2_t_q, s2_t_d;
    logic [DATA_WIDTH-1:0] s2_inv_q, s2_beta_q;
    logic                  s2_relu_q, s2_last_q;
    logic [CH_W-1:0]       s2_ch_q;

    // Stage 3: inv_den scale, beta offset, saturation, ReLU
    logic signed [U_W-1:0] s3_prod;
    logic signed [S_W-1:0] s3_u;
    logic [HI_W-1:0]       s3_hi;
    logic [DATA_WIDTH-1:0] s3_res_d;

    // A full output register that is not being taken freezes the whole pipe
    assign in_ready = !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready && !clr;
    assign prm_hit  = prm_we && (32'(prm_addr) < FILTERS);
    assign last_c   = (pos_q == POS_W'(SPATIAL - 1)) && (ch_q == CH_W'(FILTERS - 1));

    // Parameter file writes; reset to the identity transform
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beta_q  <= '{default: '0};
            gamma_q <= '{default: ONE};
            mean_q  <= '{default: '0};
            inv_q   <= '{default: ONE};
        end else if (prm_hit) begin
            unique case (prm_sel)
                2'd0: beta_q[prm_addr]  <= prm_data;
                2'd1: gamma_q[prm_addr] <= prm_data;
                2'd2: mean_q[prm_addr]  <= prm_data;
                2'd3: inv_q[prm_addr]   <= prm_data;
            endcase
        end
    end

    // Next position/channel on each accepted element
    always_comb begin
        pos_d = pos_q;
        ch_d  = ch_q;
        if (accept) begin
            if (pos_q == POS_W'(SPATIAL - 1)) begin
                pos_d = '0;
                ch_d  = (ch_q == CH_W'(FILTERS - 1)) ? '0 : ch_q + CH_W'(1);
            end else begin
                pos_d = pos_q + POS_W'(1);
            end
        end
    end

    // Position/channel registers, zeroed by clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0;
            ch_q  <= '0;
        end else if (clr) begin
            pos_q <= '0;
            ch_q  <= '0;
        end else begin
            pos_q <= pos_d;
            ch_q  <= ch_d;
        end
    end

    assign s1_d_d = {in_data[DATA_WIDTH-1], in_data} - {mean_q[ch_q][DATA_WIDTH-1], mean_q[ch_q]};

    // Stage 1 register: capture x - mean and the element's parameters at acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_d_q     <= '0;
            s1_gamma_q <= '0;
            s1_inv_q   <= '0;
            s1_beta_q  <= '0;
            s1_relu_q  <= RELU_EN;
            s1_last_q  <= 1'b0;
            s1_ch_q    <= '0;
        end else if (clr) begin
            s1_vld_q <= 1'b0;
        end else if (in_ready) begin
            s1_vld_q <= accept;
            if (accept) begin
                s1_d_q     <= s1_d_d;
                s1_gamma_q <= gamma_q[ch_q];
                s1_inv_q   <= inv_q[ch_q];
                s1_beta_q  <= beta_q[ch_q];
                s1_relu_q  <= relu_i;
                s1_last_q  <= last_c;
                s1_ch_q    <= ch_q;
            end
        end
    end

    assign s2_prod = T_W'($signed(s1_d_q)) * T_W'($signed(s1_gamma_q));
    assign s2_t_d  = T_W'(s2_prod >>> FRAC_BITS);

    // Stage 2 register: floor-scaled gamma product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q  <= 1'b0;
            s2_t_q    <= '0;
            s2_inv_q  <= '0;
            s2_beta_q <= '0;
            s2_relu_q <= RELU_EN;
            s2_last_q <= 1'b0;
            s2_ch_q   <= '0;
        end else if (clr) begin
            s2_vld_q <= 1'b0;
        end else if (in_ready) begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_t_q    <= s2_t_d;
                s2_inv_q  <= s1_inv_q;
                s2_beta_q <= s1_beta_q;
                s2_relu_q <= s1_relu_q;
                s2_last_q <= s1_last_q;
                s2_ch_q   <= s1_ch_q;
            end
        end
    end

    assign s3_prod = U_W'($signed(s2_t_q)) * U_W'($signed(s2_inv_q));
    assign s3_u    = S_W'(s3_prod >>> FRAC_BITS) + S_W'($signed(s2_beta_q));
    assign s3_hi   = s3_u[S_W-1:DATA_WIDTH-1];

    // Saturate to the signed word range, then clamp negatives when ReLU is on
    always_comb begin
        s3_res_d = s3_u[DATA_WIDTH-1:0];
        if ((s3_hi != '0) && (s3_hi != '1)) begin
            s3_res_d = s3_u[S_W-1] ? SAT_MIN : SAT_MAX;
        end
        if (s2_relu_q && s3_res_d[DATA_WIDTH-1]) begin
            s3_res_d = '0;
        end
    end

    // Output register; held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else if (clr) begin
            out_valid <= 1'b0;
        end else if (in_ready) begin
            out_valid <= s2_vld_q;
            if (s2_vld_q) begin
                out_data <= s3_res_d;
                out_ch   <= s2_ch_q;
                out_last <= s2_last_q;
            end
        end
    end

endmodule

// File: tb/tb_batch_normalization_stream.sv
// Bench for batch_normalization_stream: directed and random stimulus against an arithmetic model.
module tb_batch_normalization_stream;

    localparam int FILTERS = 2;
    localparam int SPATIAL = 4;
    localparam int FRAME   = FILTERS * SPATIAL;

    logic        clk = 1'b0;
    logic        rst_n, clr, relu_i, in_valid, in_ready, out_valid, out_ready, out_last, prm_we;
    logic [15:0] in_data, out_data, prm_data;
    logic [0:0]  out_ch, prm_addr;
    logic [1:0]  prm_sel;

    batch_normalization_stream #(
        .DATA_WIDTH(16), .FRAC_BITS(8), .FILTERS(2), .DEPTH(1), .INPUT(2), .RELU_EN(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .relu_i(relu_i),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_last(out_last),
        .prm_we(prm_we), .prm_sel(prm_sel), .prm_addr(prm_addr), .prm_data(prm_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          ch;
        logic        last;
    } item_t;

    item_t              exp_q[$];
    item_t              log_q[$];
    logic signed [15:0] m_beta [FILTERS];
    logic signed [15:0] m_gamma[FILTERS];
    logic signed [15:0] m_mean [FILTERS];
    logic signed [15:0] m_inv  [FILTERS];
    int                 n_acc, tests, fails, cyc, acc_cyc, out_cyc;
    bit                 acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < FILTERS; i++) begin
            m_beta[i]  = 16'sh0000;
            m_gamma[i] = 16'sh0100;
            m_mean[i]  = 16'sh0000;
            m_inv[i]   = 16'sh0100;
        end
        exp_q.delete();
        n_acc = 0;
    endtask

    // Fixed-point batch norm with plain integer arithmetic (>>> on signed = floor)
    function automatic logic [15:0] ref_bn(input logic [15:0] x, input int c, input logic relu);
        longint d, t, u;
        d = longint'($signed(x)) - longint'(m_mean[c]);
        t = (d * longint'(m_gamma[c])) >>> 8;
        u = ((t * longint'(m_inv[c])) >>> 8) + longint'(m_beta[c]);
        if (u > 32767) u = 32767;
        if (u < -32768) u = -32768;
        if (relu && u < 0) u = 0;
        return 16'(u);
    endfunction

    function automatic item_t get_log(input int i);
        item_t e;
        e.data = 'x;
        e.ch   = -1;
        e.last = 1'bx;
        if (i < log_q.size()) e = log_q[i];
        return e;
    endfunction

    // One clock: sample just before the edge, score outputs, model acceptance and writes
    task automatic step();
        item_t e;
        int    c;
        #4;
        check("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
        if (exp_q.size() == 0) begin
            check("idle_out_valid", 64'(out_valid), 64'(0));
        end else if (out_valid) begin
            check("out_data", 64'(out_data), 64'(exp_q[0].data));
            check("out_ch", 64'(out_ch), 64'(exp_q[0].ch));
            check("out_last", 64'(out_last), 64'(exp_q[0].last));
            if (out_ready) begin
                e.data = out_data;
                e.ch   = int'(out_ch);
                e.last = out_last;
                log_q.push_back(e);
                void'(exp_q.pop_front());
                out_cyc = cyc;
            end
        end
        acc = in_valid && in_ready && !clr;
        if (acc) begin
            c      = (n_acc / SPATIAL) % FILTERS;
            e.data = ref_bn(in_data, c, relu_i);
            e.ch   = c;
            e.last = (n_acc % FRAME) == FRAME - 1;
            exp_q.push_back(e);
            n_acc++;
            acc_cyc = cyc;
        end
        if (prm_we && int'(prm_addr) < FILTERS) begin
            case (prm_sel)
                2'd0: m_beta[int'(prm_addr)]  = prm_data;
                2'd1: m_gamma[int'(prm_addr)] = prm_data;
                2'd2: m_mean[int'(prm_addr)]  = prm_data;
                default: m_inv[int'(prm_addr)] = prm_data;
            endcase
        end
        if (clr) begin
            exp_q.delete();
            n_acc = 0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [15:0] x, input logic relu, input bit rnd);
        int k;
        in_data  = x;
        relu_i   = relu;
        in_valid = 1'b1;
        k = 0;
        do begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            step();
            k++;
        end while (!acc && k < 100);
        if (!acc) check("send_timeout", 64'(acc), 64'(1));
    endtask

    task automatic drain(input bit rnd);
        int k;
        in_valid = 1'b0;
        k = 0;
        while (exp_q.size() > 0 && k < 200) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'(0));
        out_ready = 1'b1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [0:0] addr, input logic [15:0] val);
        prm_we   = 1'b1;
        prm_sel  = sel;
        prm_addr = addr;
        prm_data = val;
        step();
        prm_we   = 1'b0;
    endtask

    task automatic clr_pulse();
        in_valid = 1'b0;
        clr      = 1'b1;
        step();
        clr      = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        item_t e;
        rst_n = 1'b0; clr = 1'b0; relu_i = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b1; prm_we = 1'b0; prm_sel = '0; prm_addr = '0; prm_data = '0;
        tests = 0; fails = 0; cyc = 0; acc_cyc = 0; out_cyc = 0; acc = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_ch", 64'(out_ch), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        rst_n = 1'b1;
        @(negedge clk);

        // Basic arithmetic and latency
        wr(2'd2, 1'b0, 16'h0100);
        wr(2'd1, 1'b0, 16'h0200);
        wr(2'd3, 1'b0, 16'h0080);
        wr(2'd0, 1'b0, 16'h0040);
        log_q.delete();
        send(16'h0300, 1'b0, 1'b0);
        drain(1'b0);
        check("basic_count", 64'(log_q.size()), 64'(1));
        e = get_log(0);
        check("basic_data", 64'(e.data), 64'(16'h0240));
        check("basic_ch", 64'(e.ch), 64'(0));
        check("basic_latency", 64'(out_cyc - acc_cyc), 64'(3));

        // Saturation and ReLU
        wr(2'd2, 1'b0, 16'h8100);
        wr(2'd3, 1'b0, 16'h0100);
        wr(2'd0, 1'b0, 16'h0000);
        log_q.delete();
        send(16'h7F00, 1'b0, 1'b0);
        drain(1'b0);
        e = get_log(0);
        check("sat_pos", 64'(e.data), 64'(16'h7FFF));
        wr(2'd2, 1'b0, 16'h7F00);
        send(16'h8100, 1'b0, 1'b0);
        drain(1'b0);
        e = get_log(1);
        check("sat_neg", 64'(e.data), 64'(16'h8000));
        send(16'h8100, 1'b1, 1'b0);
        drain(1'b0);
        e = get_log(2);
        check("relu_neg", 64'(e.data), 64'(16'h0000));

        // clr mid-frame with two in flight and a simultaneous element offered
        log_q.delete();
        send(16'h0001, 1'b0, 1'b0);
        send(16'h0002, 1'b0, 1'b0);
        in_data = 16'h0055;
        clr     = 1'b1;
        step();
        clr = 1'b0;
        in_valid = 1'b0;
        repeat (6) step();
        check("clr_dropped", 64'(log_q.size()), 64'(0));
        send(16'h0000, 1'b0, 1'b0);
        drain(1'b0);
        e = get_log(0);
        check("clr_params_kept", 64'(e.data), 64'(16'h8000));
        check("clr_ch0", 64'(e.ch), 64'(0));

        // Channel sequencing over a full frame plus one
        clr_pulse();
        wr(2'd2, 1'b0, 16'h0000);
        wr(2'd1, 1'b0, 16'h0100);
        wr(2'd0, 1'b0, 16'h0100);
        wr(2'd0, 1'b1, 16'h0200);
        log_q.delete();
        for (int i = 0; i < 9; i++) send(16'h0000, 1'b0, 1'b0);
        drain(1'b0);
        check("seq_count", 64'(log_q.size()), 64'(9));
        for (int i = 0; i < 9; i++) begin
            e = get_log(i);
            check("seq_data", 64'(e.data), (i >= 4 && i < 8) ? 64'(16'h0200) : 64'(16'h0100));
            check("seq_ch", 64'(e.ch), (i >= 4 && i < 8) ? 64'(1) : 64'(0));
            check("seq_last", 64'(e.last), 64'(i == 7));
        end

        // Backpressure with a random out_ready pattern
        log_q.delete();
        for (int i = 1; i <= 10; i++) send(16'(i), 1'b0, 1'b1);
        drain(1'b1);
        check("bp_count", 64'(log_q.size()), 64'(10));
        for (int i = 0; i < 10; i++) begin
            e = get_log(i);
            check("bp_order", 64'(e.data[7:0]), 64'(i + 1));
        end

        // Live parameter write in the acceptance cycle
        clr_pulse();
        log_q.delete();
        prm_we = 1'b1; prm_sel = 2'd0; prm_addr = 1'b0; prm_data = 16'h0080;
        send(16'h0000, 1'b0, 1'b0);
        prm_we = 1'b0;
        send(16'h0000, 1'b0, 1'b0);
        drain(1'b0);
        e = get_log(0);
        check("live_old_beta", 64'(e.data), 64'(16'h0100));
        e = get_log(1);
        check("live_new_beta", 64'(e.data), 64'(16'h0080));

        // Random traffic with random parameter writes and ReLU
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                prm_we   = 1'b1;
                prm_sel  = 2'($urandom_range(0, 3));
                prm_addr = 1'($urandom_range(0, 1));
                prm_data = 16'($urandom_range(0, 1023)) - 16'd512;
            end else begin
                prm_we = 1'b0;
            end
            send(16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        end
        prm_we = 1'b0;
        drain(1'b1);

        // Asynchronous reset mid-frame with results in flight
        out_ready = 1'b1;
        send(16'h0011, 1'b0, 1'b0);
        send(16'h0022, 1'b0, 1'b0);
        send(16'h0033, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        check("midrst_out_data", 64'(out_data), 64'(0));
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        log_q.delete();
        send(16'h0123, 1'b0, 1'b0);
        drain(1'b0);
        e = get_log(0);
        check("midrst_identity", 64'(e.data), 64'(16'h0123));
        check("midrst_ch0", 64'(e.ch), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/batch_normalization_stream.md
Name: batch_normalization_stream

Overview:
- Streaming, time-multiplexed batch-normalization engine for the CNN datapath. It replaces the fully parallel per-filter instance array with a single pipelined datapath.
- Accepts one activation per cycle on a valid/ready stream, channel-major order: all DEPTH*INPUT*INPUT elements of channel 0, then channel 1, and so on.
- Per-channel parameters sit in a runtime-writable register file and are applied as y = ((x - mean) * gamma) * inv_den + beta.
- Optional ReLU. Sits between a convolution output stream and the next layer.

Parameters:
- DATA_WIDTH, 16, signed two's-complement fixed-point word width.
- FRAC_BITS, 8, fractional bits of every word (data and parameters).
- FILTERS, 64, number of channels per frame.
- DEPTH, 1, depth of each channel slice.
- INPUT, 30, spatial side length; SPATIAL = DEPTH*INPUT*INPUT elements per channel.
- RELU_EN, 0, reset value of the ReLU mode bit.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush: zero the counters, drop the pipeline contents.
- relu_i  in  1  ReLU enable, sampled per element at acceptance.
- in_valid  in  1  input element valid.
- in_ready  out  1  block can accept an element.
- in_data  in  DATA_WIDTH  input activation.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  normalized result.
- out_ch  out  clog2(FILTERS)  channel index of out_data.
- out_last  out  1  final element of the frame.
- prm_we  in  1  parameter write strobe.
- prm_sel  in  2  target: 0 beta, 1 gamma, 2 mean, 3 inv_den.
- prm_addr  in  clog2(FILTERS)  channel to write.
- prm_data  in  DATA_WIDTH  parameter value.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_ch=0, out_last=0, in_ready=1.
  - Position and channel counters = 0; all pipeline valid bits = 0.
  - Parameter file: beta=0, mean=0, gamma=1.0, inv_den=1.0 (1<<FRAC_BITS), so the block resets to an identity transform.
- Acceptance: an element is accepted when in_valid && in_ready.
- Backpressure: in_ready = !(out_valid && !out_ready). A stall freezes every pipeline stage; no element is lost or duplicated.
- Counters:
  - pos increments on each acceptance and wraps SPATIAL-1 -> 0.
  - On that wrap, ch increments and wraps FILTERS-1 -> 0.
  - An element accepted with ch=FILTERS-1 and pos=SPATIAL-1 is tagged last.
- Pipeline: 3 stages, latency 3 cycles from acceptance to out_valid when not stalled; throughput 1 element per cycle.
  - S1: d = x - mean[ch], DATA_WIDTH+1 bits, exact.
  - S2: t = (d * gamma[ch]) >>> FRAC_BITS, full product width, arithmetic shift (floor).
  - S3: u = ((t * inv_den[ch]) >>> FRAC_BITS) + beta[ch].
  - Output: u saturates to the signed DATA_WIDTH range, i.e. max 0x7FFF / min 0x8000 at W=16. If the relu bit captured at acceptance is set and the result is negative, the output is 0.
- Parameter latching: each element's channel parameters are latched in S1 alongside x, so later stages never re-read the file.
- Parameter writes:
  - A write takes effect for elements accepted in the cycle after the prm_we cycle or later.
  - Writes are allowed during streaming and during stalls.
  - prm_addr >= FILTERS is ignored.
- clr:
  - Clears pos, ch and all valid bits in the next cycle; in-flight results are discarded.
  - Parameters are preserved.
  - clr has priority over a simultaneous acceptance; that element is dropped.
- Reset mid-frame: everything returns to reset values, including the parameters; the next accepted element is ch 0, pos 0.
- Outputs are registered. out_data, out_ch and out_last hold stable while out_valid && !out_ready.

Test Plan (W=16, FRAC=8):
- Basic arithmetic:
  - Stimulus: write ch0 mean=0x0100, gamma=0x0200, inv_den=0x0080, beta=0x0040; send x=0x0300.
  - Required: out_data=0x0240 (2.25) three cycles after acceptance, out_ch=0.
- Saturation and ReLU:
  - Stimulus: mean=0x8100, gamma=0x0200, inv_den=0x0100, beta=0; send x=0x7F00.
  - Required: 0x7FFF.
  - Then, with mean=0x7F00, x=0x8100: required 0x8000; with relu_i=1, required 0x0000.
- Channel sequencing (FILTERS=2, DEPTH=1, INPUT=2, so 8 elements per frame):
  - Stimulus: beta ch0=0x0100, ch1=0x0200; stream x=0 x8.
  - Required: outputs 0x0100 x4 with out_ch=0, then 0x0200 x4 with out_ch=1; out_last only on the 8th output; the 9th input maps back to ch0.
- Backpressure:
  - Stimulus: stream 10 ramp values 1..10 with out_ready toggled by a random pattern.
  - Required: in_ready low exactly while out_valid && !out_ready; outputs in order with no loss or duplication; data stable during the stall.
- Live parameter write:
  - Stimulus: write beta ch0=0x0080 in the same cycle an element is accepted.
  - Required: that element uses the old beta; the next element uses 0x0080.
- Reset and clr:
  - Stimulus: assert rst_n low mid-frame with 2 results in flight.
  - Required: out_valid=0 immediately; after release, identity transform (x=0x0123 -> 0x0123) and out_ch=0.
  - Stimulus: clr mid-frame.
  - Required: in-flight results dropped; parameters retained; counting restarts at ch 0.
